// File: rtl/bps_pkg.sv
// bps_pkg: shared FSM state type and counter-width helper for the pipe scheduler
package bps_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bps_fifo.sv
// bps_fifo: synchronous FIFO with occupancy count; a push on a full FIFO is accepted only alongside a pop
module bps_fifo
    import bps_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             push;
    logic             pop;

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign pop   = rd & ~empty;
    assign push  = wr & (~full | pop);
    assign rdata = empty ? '0 : mem[rp];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // storage needs no reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/balanced_pipe_scheduler.sv
// balanced_pipe_scheduler: credit-based issue/capture control for a fixed-latency balanced netlist
module balanced_pipe_scheduler
    import bps_pkg::*;
#(
    parameter int IN_W       = 5,
    parameter int OUT_W      = 2,
    parameter int DEPTH      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [GAP_W-1:0]  issue_gap,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [IN_W-1:0]   pipe_x,
    input  logic [OUT_W-1:0]  pipe_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              ovf_err
);

    localparam int IFW = cnt_w(DEPTH);
    localparam int FCW = cnt_w(FIFO_DEPTH);

    state_t           state;
    state_t           state_next;
    logic [DEPTH-1:0] tag;
    logic [IFW-1:0]   inflight;
    logic [GAP_W-1:0] gap_cnt;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic             capture;
    logic             credit;

    assign capture   = tag[DEPTH-1];
    assign credit    = int'(inflight) + int'(fifo_count) < FIFO_DEPTH;
    assign issue     = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign busy      = (inflight != '0) | ~fifo_empty;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // next state, issue permission and drain completion pulse
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        drain_done = 1'b0;
        case (state)
            RUN: begin
                in_ready   = (gap_cnt == '0) & credit & ~drain_req;
                state_next = drain_req ? DRAIN : RUN;
            end
            DRAIN: begin
                drain_done = inflight == '0;
                state_next = (inflight == '0) ? IDLE : DRAIN;
            end
            IDLE:    state_next = drain_req ? IDLE : RUN;
            default: state_next = RUN;
        endcase
    end

    // launch register, gap timer, wave tags and in-flight count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_x   <= '0;
            gap_cnt  <= '0;
            tag      <= '0;
            inflight <= '0;
            ovf_err  <= 1'b0;
        end else begin
            pipe_x   <= issue ? in_data : '0;
            gap_cnt  <= issue ? issue_gap : gap_cnt - GAP_W'(gap_cnt != '0);
            tag      <= (tag << 1) | DEPTH'(issue);
            inflight <= inflight + IFW'(issue) - IFW'(capture);
            ovf_err  <= ovf_err | (capture & fifo_full & ~out_ready);
        end
    end

    bps_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (capture),
        .wdata (pipe_y),
        .rd    (out_ready),
        .rdata (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && fifo_full && !out_ready));

endmodule
